axis_rr_arbiter: RTL and testbench

Round-robin arbiter that merges NUM_INPUTS AXI-stream sources into one AXI-stream sink, typically the input port of an `axis_fifo` instance shared by several producers. It grants one requester at a time and registers the selected beat into a single output stage. It can optionally hold a grant for a burst of up to BURST_LEN consecutive beats. Throughput is one beat per cycle; no beat is dropped, duplicated or reordered within a source.

---
 rtl/axis_rr_arbiter_if.sv | 38 +++
 rtl/axis_rr_arbiter.sv | 158 +++++++++++++++
 tb/tb_axis_rr_arbiter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/axis_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : axis_rr_arbiter_if
// Description : Handshake bundle between NUM_INPUTS AXI-stream sources, the
//               round-robin arbiter and its single AXI-stream sink.
//               idata/ivalid/iready : packed source side, source i occupies
//                                     idata[i*DATA_WIDTH +: DATA_WIDTH]
//               odata/ovalid/oready : registered sink side
//               ogrant              : source index that produced odata
//               Modport slave  : the arbiter's view.
//               Modport master : the sources-and-sink environment's view.
// Revision    : 1.0  initial release
// ============================================================================
interface axis_rr_arbiter_if #(
   parameter int NUM_INPUTS = 4,
   parameter int DATA_WIDTH = 8
);
   localparam int GW = $clog2(NUM_INPUTS);

   logic [NUM_INPUTS*DATA_WIDTH-1:0] idata;
   logic [NUM_INPUTS-1:0]            ivalid;
   logic [NUM_INPUTS-1:0]            iready;
   logic [DATA_WIDTH-1:0]            odata;
   logic                             ovalid;
   logic                             oready;
   logic [GW-1:0]                    ogrant;

   modport slave (
      input  idata, ivalid, oready,
      output iready, odata, ovalid, ogrant
   );

   modport master (
      output idata, ivalid, oready,
      input  iready, odata, ovalid, ogrant
   );
endinterface
`default_nettype wire

// File: rtl/axis_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axis_rr_arbiter
// Description : Round-robin merge of NUM_INPUTS AXI-stream sources into one
//               registered AXI-stream output stage, one beat per cycle.
//               Optional burst grant: define AXIS_ARB_BURST_EN to let a
//               granted source keep the grant for up to BURST_LEN beats.
// Ports       : clock  - sole clock, rising edge
//               resetn - asynchronous active-low reset
//               bus    - axis_rr_arbiter_if.slave (idata/ivalid/iready in,
//                        odata/ovalid/oready/ogrant out)
// Revision    : 1.0  initial release
// ============================================================================
module axis_rr_arbiter #(
   parameter int NUM_INPUTS = 4,
   parameter int DATA_WIDTH = 8,
   parameter int BURST_LEN  = 4
) (
   input  wire logic          clock,
   input  wire logic          resetn,
   axis_rr_arbiter_if.slave   bus
);
   localparam int GW = $clog2(NUM_INPUTS);

   // Elaboration-time parameter sanity checks
   if (NUM_INPUTS < 2) begin : g_bad_inputs
      $error("axis_rr_arbiter: NUM_INPUTS must be at least 2");
   end
   if (BURST_LEN < 1) begin : g_bad_burst
      $error("axis_rr_arbiter: BURST_LEN must be at least 1");
   end

`ifdef AXIS_ARB_BURST_EN
   localparam int CW = $clog2(BURST_LEN + 1);

   typedef enum logic [0:0] {
      ST_ARB  = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
`endif

   logic [GW-1:0]         r_cur;     // last granted source
   logic [DATA_WIDTH-1:0] r_odata;
   logic                  r_ovalid;
   logic [GW-1:0]         r_ogrant;

   logic                  w_load;
   logic                  w_any_valid;
   logic [GW-1:0]         w_sel;
   logic [GW-1:0]         w_grant;
   logic [NUM_INPUTS-1:0] w_iready;
   logic                  w_xfer;

   // Output slot is free or being drained this cycle
   assign w_load      = !r_ovalid || bus.oready;
   assign w_any_valid = |bus.ivalid;

   // Rotating priority search starting just after r_cur. The loop walks from
   // lowest to highest priority so the last hit is the winner.
   always_comb begin
      w_sel = r_cur;
      for (int k = NUM_INPUTS; k >= 1; k--) begin
         if (bus.ivalid[(int'(r_cur) + k) % NUM_INPUTS]) begin
            w_sel = GW'((int'(r_cur) + k) % NUM_INPUTS);
         end
      end
   end

`ifdef AXIS_ARB_BURST_EN
   // While holding, only the current owner is offered ready, so activity on
   // other ports cannot disturb the burst.
   assign w_grant = (r_state == ST_HOLD) ? r_cur : w_sel;
`else
   assign w_grant = w_sel;
`endif

   always_comb begin
      w_iready = '0;
      if (resetn) begin
`ifdef AXIS_ARB_BURST_EN
         if (r_state == ST_HOLD) begin
            w_iready[r_cur] = w_load;
         end else if (w_any_valid) begin
            w_iready[w_sel] = w_load;
         end
`else
         if (w_any_valid) begin
            w_iready[w_sel] = w_load;
         end
`endif
      end
   end

   assign w_xfer     = |(w_iready & bus.ivalid);
   assign bus.iready = w_iready;
   assign bus.odata  = r_odata;
   assign bus.ovalid = r_ovalid;
   assign bus.ogrant = r_ogrant;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_cur    <= GW'(NUM_INPUTS - 1);
         r_odata  <= '0;
         r_ovalid <= 1'b0;
         r_ogrant <= '0;
`ifdef AXIS_ARB_BURST_EN
         r_state  <= ST_ARB;
         r_cnt    <= '0;
`endif
      end else begin
         // Output register
         if (w_load) begin
            r_ovalid <= w_xfer;
            if (w_xfer) begin
               r_odata  <= bus.idata[w_grant*DATA_WIDTH +: DATA_WIDTH];
               r_ogrant <= w_grant;
            end
         end

`ifdef AXIS_ARB_BURST_EN
         case (r_state)
            ST_ARB: begin
               if (w_xfer) begin
                  r_cur <= w_sel;
                  if (BURST_LEN > 1) begin
                     r_state <= ST_HOLD;
                     r_cnt   <= CW'(1);
                  end
               end
            end
            ST_HOLD: begin
               // Sink stall keeps the grant and count frozen
               if (w_load) begin
                  if (bus.ivalid[r_cur]) begin
                     r_cnt <= r_cnt + CW'(1);
                     if (r_cnt == CW'(BURST_LEN - 1)) begin
                        r_state <= ST_ARB;
                     end
                  end else begin
                     // Source left a gap: give up the grant, no transfer
                     r_state <= ST_ARB;
                  end
               end
            end
            default: r_state <= ST_ARB;
         endcase
`else
         if (w_xfer) begin
            r_cur <= w_sel;
         end
`endif
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_axis_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_rr_arbiter
// Description : Directed self-checking bench for axis_rr_arbiter (4 inputs,
//               8-bit data, BURST_LEN 4). Expected grant/data sequences are
//               selected by AXIS_ARB_BURST_EN to match the build.
// Revision    : 1.0  initial release
// ============================================================================
module tb_axis_rr_arbiter;
   localparam int N  = 4;
   localparam int DW = 8;
   localparam int BL = 4;

   logic clock;
   logic resetn;

   axis_rr_arbiter_if #(.NUM_INPUTS(N), .DATA_WIDTH(DW)) bus ();

   axis_rr_arbiter #(
      .NUM_INPUTS (N),
      .DATA_WIDTH (DW),
      .BURST_LEN  (BL)
   ) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Per-source beat queues; a source presents its head beat until accepted
   logic [7:0] q_data [N][16];
   int         q_head [N];
   int         q_tail [N];
   logic [N-1:0] seen_ready;

   task automatic q_clear();
      for (int s = 0; s < N; s++) begin
         q_head[s] = 0;
         q_tail[s] = 0;
      end
   endtask

   task automatic q_push(input int s, input logic [7:0] d);
      q_data[s][q_tail[s]] = d;
      q_tail[s]++;
   endtask

   task automatic drive();
      for (int s = 0; s < N; s++) begin
         bus.ivalid[s] = (q_head[s] < q_tail[s]);
         bus.idata[s*DW +: DW] = (q_head[s] < q_tail[s]) ? q_data[s][q_head[s]] : 8'h00;
      end
   endtask

   // Called at posedge+1; returns at the following posedge+1 with
   // accepted beats popped and new inputs driven.
   task automatic step();
      logic [N-1:0] acc;
      @(negedge clock);
      seen_ready = bus.iready;
      acc = bus.iready & bus.ivalid;
      @(posedge clock);
      #1;
      for (int s = 0; s < N; s++) begin
         if (acc[s]) q_head[s]++;
      end
      drive();
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      bus.oready = 1'b1;
      q_clear();
      drive();
      repeat (2) @(posedge clock);
      #1;
      resetn = 1'b1;
   endtask

`ifdef AXIS_ARB_BURST_EN
   localparam bit BURST = 1'b1;
`else
   localparam bit BURST = 1'b0;
`endif

   initial begin
      int exp_g [16];
      int exp_i [16];
      logic       gv [6];
      int         gg [6];
      logic [7:0] gd [6];

      resetn = 1'b0;
      bus.oready = 1'b1;
      q_clear();
      drive();

      // ---------------- reset state, with sources requesting ------------
      @(posedge clock);
      #1;
      for (int s = 0; s < N; s++) q_push(s, 8'hEE);
      drive();
      #1;
      chk("rst_iready", 32'(bus.iready), 32'h0);
      chk("rst_ovalid", 32'(bus.ovalid), 32'h0);
      chk("rst_odata",  32'(bus.odata),  32'h0);
      chk("rst_ogrant", 32'(bus.ogrant), 32'h0);

      // ---------------- single source 2 ---------------------------------
      do_reset();
      q_push(2, 8'hA5);
      drive();
      step();
      chk("s2_iready", 32'(seen_ready),  32'b0100);
      chk("s2_ovalid", 32'(bus.ovalid),  32'h1);
      chk("s2_odata",  32'(bus.odata),   32'hA5);
      chk("s2_ogrant", 32'(bus.ogrant),  32'h2);
      step();
      chk("s2_idle",   32'(bus.ovalid),  32'h0);

      // ---------------- all sources continuously valid ------------------
      do_reset();
      for (int s = 0; s < N; s++)
         for (int j = 0; j < 4; j++) q_push(s, 8'(s*16 + j));
      drive();
      if (BURST) begin
         exp_g = '{0,0,0,0, 1,1,1,1, 2,2,2,2, 3,3,3,3};
         exp_i = '{0,1,2,3, 0,1,2,3, 0,1,2,3, 0,1,2,3};
      end else begin
         exp_g = '{0,1,2,3, 0,1,2,3, 0,1,2,3, 0,1,2,3};
         exp_i = '{0,0,0,0, 1,1,1,1, 2,2,2,2, 3,3,3,3};
      end
      for (int k = 0; k < 16; k++) begin
         step();
         chk($sformatf("rr_valid%0d", k), 32'(bus.ovalid), 32'h1);
         chk($sformatf("rr_grant%0d", k), 32'(bus.ogrant), 32'(exp_g[k]));
         chk($sformatf("rr_data%0d",  k), 32'(bus.odata),  32'(exp_g[k]*16 + exp_i[k]));
      end

      // ---------------- source 1 gap, source 3 waiting ------------------
      do_reset();
      q_push(1, 8'h11); q_push(1, 8'h12);
      q_push(3, 8'h31); q_push(3, 8'h32); q_push(3, 8'h33);
      drive();
      if (BURST) begin
         gv = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
         gg = '{1, 1, 0, 3, 3, 3};
         gd = '{8'h11, 8'h12, 8'h00, 8'h31, 8'h32, 8'h33};
      end else begin
         gv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
         gg = '{1, 3, 1, 3, 3, 0};
         gd = '{8'h11, 8'h31, 8'h12, 8'h32, 8'h33, 8'h00};
      end
      for (int k = 0; k < 6; k++) begin
         step();
         chk($sformatf("gap_valid%0d", k), 32'(bus.ovalid), 32'(gv[k]));
         if (gv[k]) begin
            chk($sformatf("gap_grant%0d", k), 32'(bus.ogrant), 32'(gg[k]));
            chk($sformatf("gap_data%0d",  k), 32'(bus.odata),  32'(gd[k]));
         end
      end

      // ---------------- sink stall with full output ---------------------
      do_reset();
      for (int j = 0; j < 6; j++) q_push(0, 8'(8'h01 + j));
      drive();
      step();
      chk("st_first", 32'(bus.odata), 32'h01);
      bus.oready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         chk($sformatf("st_iready%0d", k), 32'(seen_ready), 32'h0);
         chk($sformatf("st_valid%0d",  k), 32'(bus.ovalid), 32'h1);
         chk($sformatf("st_data%0d",   k), 32'(bus.odata),  32'h01);
         chk($sformatf("st_grant%0d",  k), 32'(bus.ogrant), 32'h0);
      end
      bus.oready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         chk($sformatf("st_after_valid%0d", k), 32'(bus.ovalid), 32'h1);
         chk($sformatf("st_after_data%0d",  k), 32'(bus.odata),  32'(8'h02 + k));
      end

      // ---------------- reset mid-burst on source 0 ---------------------
      do_reset();
      for (int j = 0; j < 8; j++) q_push(0, 8'(8'h41 + j));
      drive();
      step();
      step();
      chk("mr_pre_data", 32'(bus.odata), 32'h42);
      #2;
      resetn = 1'b0;
      #1;
      chk("mr_ovalid", 32'(bus.ovalid), 32'h0);
      chk("mr_odata",  32'(bus.odata),  32'h0);
      chk("mr_ogrant", 32'(bus.ogrant), 32'h0);
      q_clear();
      q_push(0, 8'hA1);
      q_push(1, 8'hB1);
      drive();
      @(negedge clock);
      chk("mr_iready_in_rst", 32'(bus.iready), 32'h0);
      @(posedge clock);
      #1;
      resetn = 1'b1;
      step();
      chk("mr_first_ready", 32'(seen_ready), 32'b0001);
      chk("mr_first_grant", 32'(bus.ogrant), 32'h0);
      chk("mr_first_data",  32'(bus.odata),  32'hA1);
      if (BURST) begin
         step();
         chk("mr_gap_valid", 32'(bus.ovalid), 32'h0);
      end
      step();
      chk("mr_next_valid", 32'(bus.ovalid), 32'h1);
      chk("mr_next_grant", 32'(bus.ogrant), 32'h1);
      chk("mr_next_data",  32'(bus.odata),  32'hB1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
